div_unit: RTL and testbench

- Multi-cycle integer divider for the RV32M DIV/DIVU/REM/REMU instructions, in the execute stage.
- Responder side of the decoder's divide-hazard handshake: accepts an operation, runs a radix-2 restoring division, and returns `div_ready` together with the result and its writeback tag.
- The decoder stays stalled until `div_ready`.

---
 rtl/div_unit.sv | 170 +++++++++++++++++
 tb/tb_div_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow finish at accept; all other ops take 34 cycles.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            start,
  input  logic [3:0]      div_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            div_ready,
  output logic [XLEN-1:0] result,
  output logic            reg_we,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0]      OP_DIV   = 4'd1;
  localparam logic [3:0]      OP_DIVU  = 4'd2;
  localparam logic [3:0]      OP_REM   = 4'd3;
  localparam logic [3:0]      OP_REMU  = 4'd4;
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

  // Two's-complement negation when neg is set, pass-through otherwise.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
    magnitude = neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic op_valid(input logic [3:0] op);
    op_valid = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [3:0]        op_r, op_s;
  logic              a_neg_r, a_neg_s;
  logic              b_neg_r, b_neg_s;
  logic [XLEN-1:0]   quo_r, quo_s;
  logic [XLEN-1:0]   rem_r, rem_s;
  logic [XLEN-1:0]   dvs_r, dvs_s;
  logic [XLEN-1:0]   result_s;
  logic [4:0]        rd_s;
  logic [XLEN:0]     rem_sh_s;
  logic              signed_op_s;
  logic              is_div_s;
  logic              accept_s;

  // Next-state, datapath and result selection.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    op_s        = op_r;
    a_neg_s     = a_neg_r;
    b_neg_s     = b_neg_r;
    quo_s       = quo_r;
    rem_s       = rem_r;
    dvs_s       = dvs_r;
    result_s    = result;
    rd_s        = rd_out;
    rem_sh_s    = {rem_r, quo_r[XLEN-1]};
    signed_op_s = (div_op == OP_DIV) || (div_op == OP_REM);
    is_div_s    = (div_op == OP_DIV) || (div_op == OP_DIVU);
    accept_s    = start && run && op_valid(div_op);

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          op_s    = div_op;
          rd_s    = rd_in;
          a_neg_s = signed_op_s & a[XLEN-1];
          b_neg_s = signed_op_s & b[XLEN-1];
          quo_s   = magnitude(a, signed_op_s & a[XLEN-1]);
          dvs_s   = magnitude(b, signed_op_s & b[XLEN-1]);
          rem_s   = ZERO;
          cnt_s   = CNT_W'(XLEN - 1);
          if (b == ZERO) begin
            result_s = is_div_s ? ALL_ONES : a;
            state_s  = DONE;
          end else if (signed_op_s && (a == MIN_NEG) && (b == ALL_ONES)) begin
            result_s = is_div_s ? MIN_NEG : ZERO;
            state_s  = DONE;
          end else begin
            state_s = CALC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        // The shifted partial remainder can need one extra bit before the compare.
        if (rem_sh_s >= {1'b0, dvs_r}) begin
          rem_s = rem_sh_s[XLEN-1:0] - dvs_r;
          quo_s = {quo_r[XLEN-2:0], 1'b1};
        end else begin
          rem_s = rem_sh_s[XLEN-1:0];
          quo_s = {quo_r[XLEN-2:0], 1'b0};
        end
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = FIX;
        end else begin
          cnt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          state_s = CALC;
        end
      end
      FIX: begin
        case (op_r)
          OP_DIV:  result_s = magnitude(quo_r, a_neg_r ^ b_neg_r);
          OP_DIVU: result_s = quo_r;
          OP_REM:  result_s = magnitude(rem_r, a_neg_r);
          OP_REMU: result_s = rem_r;
          default: result_s = ZERO;
        endcase
        state_s = DONE;
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      op_r      <= 4'd0;
      a_neg_r   <= 1'b0;
      b_neg_r   <= 1'b0;
      quo_r     <= ZERO;
      rem_r     <= ZERO;
      dvs_r     <= ZERO;
      result    <= ZERO;
      rd_out    <= 5'd0;
      busy      <= 1'b0;
      div_ready <= 1'b0;
      reg_we    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      op_r      <= op_s;
      a_neg_r   <= a_neg_s;
      b_neg_r   <= b_neg_s;
      quo_r     <= quo_s;
      rem_r     <= rem_s;
      dvs_r     <= dvs_s;
      result    <= result_s;
      rd_out    <= rd_s;
      busy      <= (state_s == CALC) || (state_s == FIX);
      div_ready <= (state_s == DONE);
      reg_we    <= (state_s == DONE) && (rd_s != 5'd0);
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// special cases, handshake protocol and mid-operation reset.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        run;
  logic        start;
  logic [3:0]  div_op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        div_ready;
  logic [31:0] result;
  logic        reg_we;
  logic [4:0]  rd_out;

  int checks;
  int errors;

  div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .start     (start),
    .div_op    (div_op),
    .a         (a),
    .b         (b),
    .rd_in     (rd_in),
    .busy      (busy),
    .div_ready (div_ready),
    .result    (result),
    .reg_we    (reg_we),
    .rd_out    (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op at a negedge and wait (bounded) for div_ready; lat = -1 on timeout.
  task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic [4:0] rd, output int lat, output logic [31:0] res,
                        output logic we, output logic [4:0] rdo);
    @(negedge clk);
    run = 1'b1; div_op = op; a = av; b = bv; rd_in = rd; start = 1'b1;
    lat = -1; res = 32'h0; we = 1'b0; rdo = 5'd0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0; a = 32'hDEADBEEF; b = 32'h00000001;
      end
      if (div_ready) begin
        lat = i; res = result; we = reg_we; rdo = rd_out;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (div_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", div_ready); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (rd_out !== 5'd0 || reg_we !== 1'b0) begin errors++; $display("FAIL reset_rd_we got rd=%0d we=%0b want 0/0", rd_out, reg_we); end
    reset = 1'b1;
  endtask

  task automatic test_unsigned;
    int lat; logic [31:0] res; logic we; logic [4:0] rdo;
    run_op(4'd2, 32'd100, 32'd7, 5'd5, lat, res, we, rdo);
    checks++; if (lat !== 34) begin errors++; $display("FAIL divu_latency got %0d want 34", lat); end
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_result got %0d want 14", res); end
    checks++; if (we !== 1'b1 || rdo !== 5'd5) begin errors++; $display("FAIL divu_wb got we=%0b rd=%0d want 1/5", we, rdo); end
    @(negedge clk);
    checks++; if (div_ready !== 1'b0 || reg_we !== 1'b0) begin errors++; $display("FAIL ready_pulse got rdy=%0b we=%0b want 0/0", div_ready, reg_we); end
    checks++; if (result !== 32'd14 || busy !== 1'b0) begin errors++; $display("FAIL result_hold got %0d busy=%0b want 14/0", result, busy); end
    run_op(4'd4, 32'd100, 32'd7, 5'd5, lat, res, we, rdo);
    checks++; if (lat !== 34 || res !== 32'd2) begin errors++; $display("FAIL remu got lat=%0d res=%0d want 34/2", lat, res); end
  endtask

  task automatic test_signed;
    int lat; logic [31:0] res; logic we; logic [4:0] rdo;
    run_op(4'd1, 32'hFFFFFFF9, 32'd2, 5'd6, lat, res, we, rdo);
    checks++; if (lat !== 34 || res !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg got lat=%0d res=%h want 34/fffffffd", lat, res); end
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 5'd6, lat, res, we, rdo);
    checks++; if (lat !== 34 || res !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_neg got lat=%0d res=%h want 34/ffffffff", lat, res); end
  endtask

  task automatic test_div_zero;
    int lat; logic [31:0] res; logic we; logic [4:0] rdo;
    run_op(4'd1, 32'd123, 32'd0, 5'd7, lat, res, we, rdo);
    checks++; if (lat !== 1 || res !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_by_zero got lat=%0d res=%h want 1/ffffffff", lat, res); end
    checks++; if (we !== 1'b1 || rdo !== 5'd7) begin errors++; $display("FAIL div_by_zero_wb got we=%0b rd=%0d want 1/7", we, rdo); end
    run_op(4'd4, 32'd123, 32'd0, 5'd7, lat, res, we, rdo);
    checks++; if (lat !== 1 || res !== 32'd123) begin errors++; $display("FAIL remu_by_zero got lat=%0d res=%0d want 1/123", lat, res); end
  endtask

  task automatic test_overflow;
    int lat; logic [31:0] res; logic we; logic [4:0] rdo;
    run_op(4'd1, 32'h80000000, 32'hFFFFFFFF, 5'd8, lat, res, we, rdo);
    checks++; if (lat !== 1 || res !== 32'h80000000) begin errors++; $display("FAIL div_ovf got lat=%0d res=%h want 1/80000000", lat, res); end
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 5'd8, lat, res, we, rdo);
    checks++; if (lat !== 1 || res !== 32'h0) begin errors++; $display("FAIL rem_ovf got lat=%0d res=%h want 1/0", lat, res); end
  endtask

  task automatic test_rd_zero;
    int lat; logic [31:0] res; logic we; logic [4:0] rdo;
    run_op(4'd2, 32'd10, 32'd3, 5'd0, lat, res, we, rdo);
    checks++; if (lat !== 34 || res !== 32'd3) begin errors++; $display("FAIL rd0_result got lat=%0d res=%0d want 34/3", lat, res); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL rd0_reg_we got %0b want 0", we); end
  endtask

  task automatic test_no_accept;
    logic [3:0] ops [3];
    logic       runs [3];
    logic       seen;
    ops[0] = 4'd2; runs[0] = 1'b0;
    ops[1] = 4'd0; runs[1] = 1'b1;
    ops[2] = 4'd9; runs[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      run = runs[k]; div_op = ops[k]; a = 32'd50; b = 32'd5; rd_in = 5'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0; run = 1'b1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL no_accept_busy case=%0d got %0b want 0", k, busy); end
      seen = div_ready;
      repeat (3) begin
        @(negedge clk);
        seen = seen | div_ready;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL no_accept_ready case=%0d got %0b want 0", k, seen); end
    end
  endtask

  task automatic test_back_to_back;
    int pulses; logic [31:0] res; logic [4:0] rdo; logic done_seen;
    pulses = 0; res = 32'h0; rdo = 5'd0; done_seen = 1'b0;
    @(negedge clk);
    run = 1'b1; div_op = 4'd2; a = 32'd100; b = 32'd7; rd_in = 5'd5; start = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 5) begin
        div_op = 4'd2; a = 32'd50; b = 32'd5; rd_in = 5'd7; start = 1'b1;
      end
      if (div_ready) begin
        pulses++; res = result; rdo = rd_out;
        if (!done_seen) begin
          done_seen = 1'b1;
          div_op = 4'd2; a = 32'd50; b = 32'd5; rd_in = 5'd7; start = 1'b1;
        end
      end
      if (i == 36) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done got busy=%0b want 0", busy); end
      end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL b2b_pulses got %0d want 1", pulses); end
    checks++; if (res !== 32'd14 || rdo !== 5'd5) begin errors++; $display("FAIL b2b_result got %0d rd=%0d want 14/5", res, rdo); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] res; logic we; logic [4:0] rdo;
    @(negedge clk);
    run = 1'b1; div_op = 4'd2; a = 32'd100; b = 32'd7; rd_in = 5'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++; if (busy !== 1'b0 || div_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_flags got busy=%0b rdy=%0b want 0/0", busy, div_ready); end
    checks++; if (result !== 32'h0 || rd_out !== 5'd0) begin errors++; $display("FAIL mid_reset_result got %h rd=%0d want 0/0", result, rd_out); end
    run_op(4'd2, 32'd9, 32'd3, 5'd3, lat, res, we, rdo);
    checks++; if (lat !== 34 || res !== 32'd3) begin errors++; $display("FAIL post_reset_divu got lat=%0d res=%0d want 34/3", lat, res); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; run = 1'b0; start = 1'b0; div_op = 4'd0;
    a = 32'h0; b = 32'h0; rd_in = 5'd0;
    test_reset;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_overflow;
    test_rd_zero;
    test_no_accept;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
